// File: rtl/hack_kbd_pkg.sv
// hack_kbd_pkg: receiver states, PS/2 prefix bytes and Hack key codes
package hack_kbd_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;

    // Bytes following E1 that belong to the pause sequence and are swallowed
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    localparam logic [15:0] KEY_NONE      = 16'd0;
    localparam logic [15:0] KEY_SPACE     = 16'd32;
    localparam logic [15:0] KEY_ENTER     = 16'd128;
    localparam logic [15:0] KEY_BACKSPACE = 16'd129;
    localparam logic [15:0] KEY_LEFT      = 16'd130;
    localparam logic [15:0] KEY_UP        = 16'd131;
    localparam logic [15:0] KEY_RIGHT     = 16'd132;
    localparam logic [15:0] KEY_DOWN      = 16'd133;
    localparam logic [15:0] KEY_HOME      = 16'd134;
    localparam logic [15:0] KEY_END       = 16'd135;
    localparam logic [15:0] KEY_PGUP      = 16'd136;
    localparam logic [15:0] KEY_PGDN      = 16'd137;
    localparam logic [15:0] KEY_INSERT    = 16'd138;
    localparam logic [15:0] KEY_DELETE    = 16'd139;
    localparam logic [15:0] KEY_ESC       = 16'd140;
    localparam logic [15:0] KEY_F1        = 16'd141;
    localparam logic [15:0] KEY_F2        = 16'd142;
    localparam logic [15:0] KEY_F3        = 16'd143;
    localparam logic [15:0] KEY_F4        = 16'd144;
    localparam logic [15:0] KEY_F5        = 16'd145;
    localparam logic [15:0] KEY_F6        = 16'd146;
    localparam logic [15:0] KEY_F7        = 16'd147;
    localparam logic [15:0] KEY_F8        = 16'd148;
    localparam logic [15:0] KEY_F9        = 16'd149;
    localparam logic [15:0] KEY_F10       = 16'd150;
    localparam logic [15:0] KEY_F11       = 16'd151;
    localparam logic [15:0] KEY_F12       = 16'd152;

endpackage

// File: rtl/hack_keyboard_ps2_rx.sv
// ps2_rx: PS/2 frame receiver with synchronizer, edge detect, parity check and timeout
module ps2_rx
    import hack_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5040
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync, data_sync;
    logic          sync_prev, sync_cur, bit_in, fall, timeout;
    rx_state_t     state, state_next;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity, valid_next, err_next;
    logic [TW-1:0] idle_cnt;

    assign sync_cur = clk_sync[1];
    assign bit_in   = data_sync[1];
    assign fall     = sync_prev & ~sync_cur;
    assign timeout  = (state != RX_IDLE) & ~fall & (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset)
            state <= RX_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        valid_next = 1'b0;
        err_next   = 1'b0;
        if (timeout) begin
            state_next = RX_IDLE;
            err_next   = 1'b1;
        end else if (fall) begin
            case (state)
                RX_IDLE: begin
                    state_next = bit_in ? RX_IDLE : RX_DATA;
                    err_next   = bit_in;
                end
                RX_DATA:   state_next = (bit_cnt == 3'd7) ? RX_PARITY : RX_DATA;
                RX_PARITY: state_next = RX_STOP;
                RX_STOP: begin
                    state_next = RX_IDLE;
                    valid_next = bit_in & (^{shift, parity});
                    err_next   = ~(bit_in & (^{shift, parity}));
                end
                default:   state_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            sync_prev <= 1'b1;
            bit_cnt   <= '0;
            shift     <= '0;
            parity    <= 1'b0;
            idle_cnt  <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            sync_prev <= sync_cur;
            rx_valid  <= valid_next;
            rx_err    <= err_next;
            idle_cnt  <= (state == RX_IDLE || fall || timeout) ? '0 : idle_cnt + 1'b1;
            if (fall && state == RX_IDLE)
                bit_cnt <= '0;
            if (fall && state == RX_DATA) begin
                shift   <= {bit_in, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (fall && state == RX_PARITY)
                parity <= bit_in;
            if (valid_next)
                rx_byte <= shift;
        end
    end
endmodule

// File: rtl/hack_keyboard.sv
// hack_keyboard: PS/2 scan set 2 decoder producing the Hack keyboard register
module hack_keyboard
    import hack_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5040
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_code,
    output logic        code_valid,
    output logic        frame_err
);
    logic [7:0]  rx_byte;
    logic        ext, brk;
    logic [2:0]  pause_cnt;
    logic [15:0] hack;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (code_valid),
        .rx_err   (frame_err)
    );

    // Extended codes live in the upper half of the 9-bit selector
    always_comb begin
        hack = KEY_NONE;
        case ({ext, rx_byte})
            9'h01C: hack = 16'd65;
            9'h032: hack = 16'd66;
            9'h021: hack = 16'd67;
            9'h023: hack = 16'd68;
            9'h024: hack = 16'd69;
            9'h02B: hack = 16'd70;
            9'h034: hack = 16'd71;
            9'h033: hack = 16'd72;
            9'h043: hack = 16'd73;
            9'h03B: hack = 16'd74;
            9'h042: hack = 16'd75;
            9'h04B: hack = 16'd76;
            9'h03A: hack = 16'd77;
            9'h031: hack = 16'd78;
            9'h044: hack = 16'd79;
            9'h04D: hack = 16'd80;
            9'h015: hack = 16'd81;
            9'h02D: hack = 16'd82;
            9'h01B: hack = 16'd83;
            9'h02C: hack = 16'd84;
            9'h03C: hack = 16'd85;
            9'h02A: hack = 16'd86;
            9'h01D: hack = 16'd87;
            9'h022: hack = 16'd88;
            9'h035: hack = 16'd89;
            9'h01A: hack = 16'd90;
            9'h045: hack = 16'd48;
            9'h016: hack = 16'd49;
            9'h01E: hack = 16'd50;
            9'h026: hack = 16'd51;
            9'h025: hack = 16'd52;
            9'h02E: hack = 16'd53;
            9'h036: hack = 16'd54;
            9'h03D: hack = 16'd55;
            9'h03E: hack = 16'd56;
            9'h046: hack = 16'd57;
            9'h029: hack = KEY_SPACE;
            9'h05A: hack = KEY_ENTER;
            9'h066: hack = KEY_BACKSPACE;
            9'h076: hack = KEY_ESC;
            9'h005: hack = KEY_F1;
            9'h006: hack = KEY_F2;
            9'h004: hack = KEY_F3;
            9'h00C: hack = KEY_F4;
            9'h003: hack = KEY_F5;
            9'h00B: hack = KEY_F6;
            9'h083: hack = KEY_F7;
            9'h00A: hack = KEY_F8;
            9'h001: hack = KEY_F9;
            9'h009: hack = KEY_F10;
            9'h078: hack = KEY_F11;
            9'h007: hack = KEY_F12;
            9'h16B: hack = KEY_LEFT;
            9'h175: hack = KEY_UP;
            9'h174: hack = KEY_RIGHT;
            9'h172: hack = KEY_DOWN;
            9'h16C: hack = KEY_HOME;
            9'h169: hack = KEY_END;
            9'h17D: hack = KEY_PGUP;
            9'h17A: hack = KEY_PGDN;
            9'h170: hack = KEY_INSERT;
            9'h171: hack = KEY_DELETE;
            default: hack = KEY_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_code  <= KEY_NONE;
            ext       <= 1'b0;
            brk       <= 1'b0;
            pause_cnt <= '0;
        end else if (code_valid) begin
            if (pause_cnt != 3'd0)
                pause_cnt <= pause_cnt - 3'd1;
            else if (rx_byte == SC_PAUSE) begin
                pause_cnt <= PAUSE_TAIL;
                ext       <= 1'b0;
                brk       <= 1'b0;
            end else if (rx_byte == SC_EXT)
                ext <= 1'b1;
            else if (rx_byte == SC_BRK)
                brk <= 1'b1;
            else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (hack != KEY_NONE)
                    key_code <= brk ? ((hack == key_code) ? KEY_NONE : key_code) : hack;
            end
        end
    end
endmodule

// File: tb/tb_hack_keyboard.sv
// tb_hack_keyboard: directed PS/2 frames with hand-computed Hack key codes
module tb_hack_keyboard;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key_code;
    logic        code_valid, frame_err;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    logic        valid_d = 1'b0;
    logic [15:0] key_after = 16'hFFFF;

    localparam logic [8:0]  MAP_SC  [10] = '{9'h045, 9'h046, 9'h01A, 9'h05A, 9'h005,
                                              9'h007, 9'h171, 9'h175, 9'h029, 9'h076};
    localparam logic [15:0] MAP_KEY [10] = '{16'd48, 16'd57, 16'd90, 16'd128, 16'd141,
                                              16'd152, 16'd139, 16'd131, 16'd32, 16'd140};

    hack_keyboard #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_code   (key_code),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_d) key_after = key_code;
        valid_d = code_valid;
        if (code_valid) valid_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (6) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (6) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic frame(input logic [7:0] d, input logic par_flip, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(~^d ^ par_flip);
        ps2_bit(stop);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_key(input logic [8:0] k);
        if (k[8]) frame(8'hE0, 1'b0, 1'b1);
        frame(k[7:0], 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (key_code !== 16'd0) begin errors++; $display("FAIL reset_key got=%0d exp=0", key_code); end
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", code_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_make;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        frame(8'h1C, 1'b0, 1'b1);
        checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL make_valid_pulses got=%0d exp=%0d", valid_cnt - v0, 1); end
        checks++; if (key_after !== 16'd65) begin errors++; $display("FAIL make_key_latency got=%0d exp=65", key_after); end
        checks++; if (err_cnt !== e0) begin errors++; $display("FAIL make_no_err got=%0d exp=0", err_cnt - e0); end
    endtask

    task automatic test_break;
        send_key(9'h0F0); send_key(9'h01C);
        checks++; if (key_code !== 16'd0) begin errors++; $display("FAIL break_same got=%0d exp=0", key_code); end
        send_key(9'h01C);
        send_key(9'h0F0); send_key(9'h029);
        checks++; if (key_code !== 16'd65) begin errors++; $display("FAIL break_other got=%0d exp=65", key_code); end
    endtask

    task automatic test_ext;
        send_key(9'h16B);
        checks++; if (key_code !== 16'd130) begin errors++; $display("FAIL ext_left got=%0d exp=130", key_code); end
        send_key(9'h0E0); send_key(9'h0F0); send_key(9'h06B);
        checks++; if (key_code !== 16'd0) begin errors++; $display("FAIL ext_break got=%0d exp=0", key_code); end
        send_key(9'h06B);
        checks++; if (key_code !== 16'd0) begin errors++; $display("FAIL keypad4_idle got=%0d exp=0", key_code); end
        send_key(9'h01C); send_key(9'h06B);
        checks++; if (key_code !== 16'd65) begin errors++; $display("FAIL keypad4_held got=%0d exp=65", key_code); end
    endtask

    task automatic test_map;
        for (int i = 0; i < 10; i++) begin
            send_key(MAP_SC[i]);
            checks++;
            if (key_code !== MAP_KEY[i]) begin
                errors++; $display("FAIL map_%03h got=%0d exp=%0d", MAP_SC[i], key_code, MAP_KEY[i]);
            end
        end
        send_key(9'h01C); send_key(9'h01C);
        checks++; if (key_code !== 16'd65) begin errors++; $display("FAIL typematic got=%0d exp=65", key_code); end
        send_key(9'h032);
        checks++; if (key_code !== 16'd66) begin errors++; $display("FAIL last_wins got=%0d exp=66", key_code); end
        send_key(9'h0F0); send_key(9'h01C);
        checks++; if (key_code !== 16'd66) begin errors++; $display("FAIL break_old got=%0d exp=66", key_code); end
    endtask

    task automatic test_errors;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        frame(8'h5A, 1'b1, 1'b1);
        checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL parity_err got=%0d exp=1", err_cnt - e0); end
        checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL parity_valid got=%0d exp=0", valid_cnt - v0); end
        checks++; if (key_code !== 16'd66) begin errors++; $display("FAIL parity_key got=%0d exp=66", key_code); end
        frame(8'h5A, 1'b0, 1'b0);
        checks++; if (err_cnt !== e0 + 2) begin errors++; $display("FAIL stop_err got=%0d exp=2", err_cnt - e0); end
        checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL stop_valid got=%0d exp=0", valid_cnt - v0); end
        ps2_bit(1'b1);
        repeat (10) @(negedge clk);
        checks++; if (err_cnt !== e0 + 3) begin errors++; $display("FAIL start_err got=%0d exp=3", err_cnt - e0); end
    endtask

    task automatic test_timeout;
        int v0, e0;
        logic [7:0] d;
        d = 8'h66;
        v0 = valid_cnt; e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(d[i]);
        ps2_data = 1'b1;
        repeat (TMO - 30) @(negedge clk);
        checks++; if (err_cnt !== e0) begin errors++; $display("FAIL timeout_early got=%0d exp=0", err_cnt - e0); end
        repeat (60) @(negedge clk);
        checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL timeout_err got=%0d exp=1", err_cnt - e0); end
        checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL timeout_valid got=%0d exp=0", valid_cnt - v0); end
        frame(8'h66, 1'b0, 1'b1);
        checks++; if (key_code !== 16'd129) begin errors++; $display("FAIL after_timeout got=%0d exp=129", key_code); end
    endtask

    task automatic test_reset_mid;
        int v0, e0;
        logic [7:0] d;
        d = 8'h76;
        send_key(9'h01C);
        v0 = valid_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(d[i]);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (key_code !== 16'd0) begin errors++; $display("FAIL midreset_key got=%0d exp=0", key_code); end
        e0 = err_cnt;
        ps2_bit(d[5]);
        repeat (10) @(negedge clk);
        checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL resume_err got=%0d exp=1", err_cnt - e0); end
        checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL midreset_valid got=%0d exp=0", valid_cnt - v0); end
        frame(8'h76, 1'b0, 1'b1);
        checks++; if (key_code !== 16'd140) begin errors++; $display("FAIL after_reset got=%0d exp=140", key_code); end
    endtask

    task automatic test_pause;
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) frame(seq[i], 1'b0, 1'b1);
        checks++; if (key_code !== 16'd140) begin errors++; $display("FAIL pause_key got=%0d exp=140", key_code); end
        send_key(9'h01C);
        checks++; if (key_code !== 16'd65) begin errors++; $display("FAIL after_pause got=%0d exp=65", key_code); end
    endtask

    initial begin
        test_reset;
        test_make;
        test_break;
        test_ext;
        test_map;
        test_errors;
        test_timeout;
        test_reset_mid;
        test_pause;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
